// File: rtl/tx_msg_prio_reg_ctrl.sv
// Transmit-priority table shared by the egress extern (port 0, always served) and a
// valid/ready control port (port 1). Optional counters are enabled with TX_PRIO_REG_STATS_EN.
module tx_msg_prio_reg_ctrl #(
  parameter int unsigned       NUM_ENTRIES  = 1024,
  parameter int unsigned       IDX_W        = 16,
  parameter int unsigned       PRIO_W       = 8,
  parameter logic [PRIO_W-1:0] DEFAULT_PRIO = PRIO_W'(8'hFF)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              p0_req_valid,
  input  logic [IDX_W-1:0]  p0_req_index,
  input  logic              p0_req_update,
  input  logic [PRIO_W-1:0] p0_req_prio,
  output logic              p0_resp_valid,
  output logic [PRIO_W-1:0] p0_resp_prio,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic [IDX_W-1:0]  p1_req_index,
  input  logic              p1_req_update,
  input  logic [PRIO_W-1:0] p1_req_prio,
  output logic              p1_resp_valid,
  output logic [PRIO_W-1:0] p1_resp_prio,
  output logic              init_done,
  output logic              oor_err
`ifdef TX_PRIO_REG_STATS_EN
  ,
  output logic [31:0]       p0_ops_cnt,
  output logic [31:0]       p1_stall_cnt,
  output logic [31:0]       upd_cnt
`endif
);

  // state   | meaning
  // ST_INIT | sweeping DEFAULT_PRIO into every entry; p1 held off
  // ST_RUN  | serving requests, p0 has strict priority over p1

  localparam int unsigned      AW        = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [IDX_W:0]   RANGE_LIM = (IDX_W+1)'(NUM_ENTRIES);
  localparam logic [AW-1:0]    LAST_IDX  = AW'(NUM_ENTRIES - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SRC_MEM  = 2'd0,
    SRC_DFLT = 2'd1,
    SRC_ZERO = 2'd2
  } src_t;

  state_t            state;
  state_t            state_nxt;
  logic [AW-1:0]     init_cnt;
  logic [AW-1:0]     init_cnt_nxt;
  logic              init_done_nxt;

  logic              run;
  logic              p1_fire;
  logic              acc_req;
  logic              acc_valid;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_upd;
  logic [PRIO_W-1:0] acc_prio;
  logic              acc_oor;

  logic              mem_rd;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [AW-1:0]     mem_raddr;
  logic [PRIO_W-1:0] mem_wdata;
  logic [PRIO_W-1:0] rd_data;
  logic [PRIO_W-1:0] mem [NUM_ENTRIES];

  src_t              rsp_src;
  logic [PRIO_W-1:0] rsp_data;
  logic [PRIO_W-1:0] p0_hold;
  logic [PRIO_W-1:0] p1_hold;

  // ---------------------------------------------------------------------------
  // Sequencer: init sweep then run
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_cnt  <= init_cnt_nxt;
      init_done <= init_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    init_cnt_nxt  = init_cnt;
    init_done_nxt = init_done;
    case (state)
      ST_INIT: begin
        init_cnt_nxt = init_cnt + 1'b1;
        if (init_cnt == LAST_IDX) begin
          state_nxt     = ST_RUN;
          init_cnt_nxt  = '0;
          init_done_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt     = ST_INIT;
        init_cnt_nxt  = '0;
        init_done_nxt = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Arbitration: p0 always wins, p1 only gets idle cycles after init
  // ---------------------------------------------------------------------------
  assign run          = (state == ST_RUN);
  assign p1_req_ready = init_done & ~p0_req_valid;
  assign p1_fire      = p1_req_valid & p1_req_ready;
  assign acc_req      = p0_req_valid | p1_fire;

  always_comb begin
    acc_idx  = p1_req_index;
    acc_upd  = p1_req_update;
    acc_prio = p1_req_prio;
    if (p0_req_valid) begin
      acc_idx  = p0_req_index;
      acc_upd  = p0_req_update;
      acc_prio = p0_req_prio;
    end
  end

  // Upper index bits beyond AW only matter here.
  assign acc_oor   = ({1'b0, acc_idx} >= RANGE_LIM);
  assign acc_valid = run & acc_req;

  // ---------------------------------------------------------------------------
  // Table storage: single port, synchronous read, read-before-write
  // ---------------------------------------------------------------------------
  assign mem_rd    = acc_valid & ~acc_oor;
  assign mem_we    = ~run | (mem_rd & acc_upd);
  assign mem_waddr = run ? acc_idx[AW-1:0] : init_cnt;
  assign mem_wdata = run ? acc_prio : DEFAULT_PRIO;
  assign mem_raddr = acc_idx[AW-1:0];

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (mem_rd) begin
      rd_data <= mem[mem_raddr];
    end
  end

  // ---------------------------------------------------------------------------
  // Responses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p0_resp_valid <= 1'b0;
      p1_resp_valid <= 1'b0;
      rsp_src       <= SRC_ZERO;
      p0_hold       <= '0;
      p1_hold       <= '0;
      oor_err       <= 1'b0;
    end else begin
      p0_resp_valid <= p0_req_valid;
      p1_resp_valid <= p1_fire;
      p0_hold       <= p0_resp_prio;
      p1_hold       <= p1_resp_prio;
      if (acc_req) begin
        if (acc_oor) begin
          rsp_src <= SRC_ZERO;
        end else if (run) begin
          rsp_src <= SRC_MEM;
        end else begin
          rsp_src <= SRC_DFLT;
        end
      end
      if (acc_req && acc_oor) begin
        oor_err <= 1'b1;
      end
    end
  end

  always_comb begin
    rsp_data = '0;
    case (rsp_src)
      SRC_MEM:  rsp_data = rd_data;
      SRC_DFLT: rsp_data = DEFAULT_PRIO;
      default:  rsp_data = '0;
    endcase
  end

  // Outside the strobe each port shows the value it last returned.
  assign p0_resp_prio = p0_resp_valid ? rsp_data : p0_hold;
  assign p1_resp_prio = p1_resp_valid ? rsp_data : p1_hold;

`ifdef TX_PRIO_REG_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating activity counters
  // ---------------------------------------------------------------------------
  logic p0_op_inc;
  logic p1_stall_inc;
  logic upd_inc;

  assign p0_op_inc    = run & p0_req_valid;
  assign p1_stall_inc = run & p1_req_valid & ~p1_req_ready;
  assign upd_inc      = mem_rd & acc_upd;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p0_ops_cnt   <= '0;
      p1_stall_cnt <= '0;
      upd_cnt      <= '0;
    end else begin
      if (p0_op_inc && (p0_ops_cnt != 32'hFFFF_FFFF)) begin
        p0_ops_cnt <= p0_ops_cnt + 32'd1;
      end
      if (p1_stall_inc && (p1_stall_cnt != 32'hFFFF_FFFF)) begin
        p1_stall_cnt <= p1_stall_cnt + 32'd1;
      end
      if (upd_inc && (upd_cnt != 32'hFFFF_FFFF)) begin
        upd_cnt <= upd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tx_msg_prio_reg_ctrl.sv
// Directed bench for tx_msg_prio_reg_ctrl with a 16-entry table.
module tb_tx_msg_prio_reg_ctrl;

  localparam int NE = 16;

  logic        clock;
  logic        reset_n;
  logic        p0_req_valid;
  logic [15:0] p0_req_index;
  logic        p0_req_update;
  logic [7:0]  p0_req_prio;
  logic        p0_resp_valid;
  logic [7:0]  p0_resp_prio;
  logic        p1_req_valid;
  logic        p1_req_ready;
  logic [15:0] p1_req_index;
  logic        p1_req_update;
  logic [7:0]  p1_req_prio;
  logic        p1_resp_valid;
  logic [7:0]  p1_resp_prio;
  logic        init_done;
  logic        oor_err;
`ifdef TX_PRIO_REG_STATS_EN
  logic [31:0] p0_ops_cnt;
  logic [31:0] p1_stall_cnt;
  logic [31:0] upd_cnt;
`endif

  int checks = 0;
  int errors = 0;

  tx_msg_prio_reg_ctrl #(
    .NUM_ENTRIES (NE),
    .IDX_W       (16),
    .PRIO_W      (8),
    .DEFAULT_PRIO(8'hFF)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .p0_req_valid (p0_req_valid),
    .p0_req_index (p0_req_index),
    .p0_req_update(p0_req_update),
    .p0_req_prio  (p0_req_prio),
    .p0_resp_valid(p0_resp_valid),
    .p0_resp_prio (p0_resp_prio),
    .p1_req_valid (p1_req_valid),
    .p1_req_ready (p1_req_ready),
    .p1_req_index (p1_req_index),
    .p1_req_update(p1_req_update),
    .p1_req_prio  (p1_req_prio),
    .p1_resp_valid(p1_resp_valid),
    .p1_resp_prio (p1_resp_prio),
    .init_done    (init_done),
    .oor_err      (oor_err)
`ifdef TX_PRIO_REG_STATS_EN
    ,
    .p0_ops_cnt   (p0_ops_cnt),
    .p1_stall_cnt (p1_stall_cnt),
    .upd_cnt      (upd_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    p0_req_valid  = 1'b0;
    p0_req_index  = '0;
    p0_req_update = 1'b0;
    p0_req_prio   = '0;
    p1_req_valid  = 1'b0;
    p1_req_index  = '0;
    p1_req_update = 1'b0;
    p1_req_prio   = '0;
  endtask

  // Drives one p1 request for a single cycle and returns what the DUT showed.
  task automatic p1_access(input logic [15:0] idx, input logic upd, input logic [7:0] prio,
                           output logic rdy, output logic vld, output logic [7:0] data);
    p1_req_valid  = 1'b1;
    p1_req_index  = idx;
    p1_req_update = upd;
    p1_req_prio   = prio;
    #1;
    rdy = p1_req_ready;
    tick();
    vld  = p1_resp_valid;
    data = p1_resp_prio;
    p1_req_valid  = 1'b0;
    p1_req_update = 1'b0;
  endtask

  task automatic wait_init(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (init_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
    checks++;
    if (oor_err !== 1'b0) begin errors++; $display("FAIL reset_oor_err: got %b expected 0", oor_err); end
    checks++;
    if (p0_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_p0_resp_valid: got %b expected 0", p0_resp_valid); end
    checks++;
    if (p1_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_p1_resp_valid: got %b expected 0", p1_resp_valid); end
    checks++;
    if (p0_resp_prio !== 8'h00) begin errors++; $display("FAIL reset_p0_resp_prio: got %h expected 00", p0_resp_prio); end
    checks++;
    if (p1_resp_prio !== 8'h00) begin errors++; $display("FAIL reset_p1_resp_prio: got %h expected 00", p1_resp_prio); end
    checks++;
    if (p1_req_ready !== 1'b0) begin errors++; $display("FAIL reset_p1_ready: got %b expected 0", p1_req_ready); end
    reset_n = 1'b1;
  endtask

  task automatic test_init_sweep();
    logic       rdy;
    logic       vld;
    logic [7:0] d;
    for (int i = 1; i <= NE; i++) begin
      tick();
      checks++;
      if (init_done !== (i == NE)) begin
        errors++;
        $display("FAIL init_done_edge%0d: got %b expected %b", i, init_done, (i == NE));
      end
      if (i == 8) begin
        p1_req_valid = 1'b1;
        #1;
        checks++;
        if (p1_req_ready !== 1'b0) begin errors++; $display("FAIL init_p1_ready: got %b expected 0", p1_req_ready); end
        p1_req_valid = 1'b0;
      end
    end
    for (int i = 0; i < NE; i++) begin
      p1_access(16'(i), 1'b0, 8'h00, rdy, vld, d);
      checks++;
      if (rdy !== 1'b1 || vld !== 1'b1 || d !== 8'hFF) begin
        errors++;
        $display("FAIL sweep_read_idx%0d: got rdy=%b vld=%b prio=%h expected rdy=1 vld=1 prio=ff", i, rdy, vld, d);
      end
    end
    tick();
    checks++;
    if (p1_resp_valid !== 1'b0 || p1_resp_prio !== 8'hFF) begin
      errors++;
      $display("FAIL p1_resp_hold: got vld=%b prio=%h expected vld=0 prio=ff", p1_resp_valid, p1_resp_prio);
    end
  endtask

  task automatic test_raw_p0();
    p0_req_valid  = 1'b1;
    p0_req_index  = 16'd5;
    p0_req_update = 1'b1;
    p0_req_prio   = 8'h03;
    tick();
    checks++;
    if (p0_resp_valid !== 1'b1 || p0_resp_prio !== 8'hFF) begin
      errors++;
      $display("FAIL p0_write_resp: got vld=%b prio=%h expected vld=1 prio=ff", p0_resp_valid, p0_resp_prio);
    end
    p0_req_update = 1'b0;
    tick();
    checks++;
    if (p0_resp_valid !== 1'b1 || p0_resp_prio !== 8'h03) begin
      errors++;
      $display("FAIL p0_read_after_write: got vld=%b prio=%h expected vld=1 prio=03", p0_resp_valid, p0_resp_prio);
    end
    p0_req_valid = 1'b0;
    tick();
    checks++;
    if (p0_resp_valid !== 1'b0 || p0_resp_prio !== 8'h03 || p1_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL p0_resp_pulse_hold: got vld=%b prio=%h p1vld=%b expected vld=0 prio=03 p1vld=0",
               p0_resp_valid, p0_resp_prio, p1_resp_valid);
    end
  endtask

  task automatic test_priority();
    logic       rdy;
    logic       vld;
    logic [7:0] d;
    p1_req_valid  = 1'b1;
    p1_req_index  = 16'd7;
    p1_req_update = 1'b1;
    p1_req_prio   = 8'h42;
    for (int c = 0; c < 4; c++) begin
      p0_req_valid  = 1'b1;
      p0_req_index  = 16'(c);
      p0_req_update = 1'b0;
      #1;
      checks++;
      if (p1_req_ready !== 1'b0) begin errors++; $display("FAIL prio_ready_cyc%0d: got %b expected 0", c, p1_req_ready); end
      tick();
      checks++;
      if (p0_resp_valid !== 1'b1 || p1_resp_valid !== 1'b0 || p0_resp_prio !== 8'hFF) begin
        errors++;
        $display("FAIL prio_p0_resp_cyc%0d: got p0vld=%b p1vld=%b prio=%h expected 1 0 ff",
                 c, p0_resp_valid, p1_resp_valid, p0_resp_prio);
      end
    end
    p0_req_valid = 1'b0;
    #1;
    checks++;
    if (p1_req_ready !== 1'b1) begin errors++; $display("FAIL prio_ready_release: got %b expected 1", p1_req_ready); end
    tick();
    p1_req_valid  = 1'b0;
    p1_req_update = 1'b0;
    checks++;
    if (p1_resp_valid !== 1'b1 || p0_resp_valid !== 1'b0 || p1_resp_prio !== 8'hFF) begin
      errors++;
      $display("FAIL prio_p1_resp: got p1vld=%b p0vld=%b prio=%h expected 1 0 ff",
               p1_resp_valid, p0_resp_valid, p1_resp_prio);
    end
    p1_access(16'd7, 1'b0, 8'h00, rdy, vld, d);
    checks++;
    if (vld !== 1'b1 || d !== 8'h42) begin
      errors++;
      $display("FAIL prio_p1_write_landed: got vld=%b prio=%h expected vld=1 prio=42", vld, d);
    end
  endtask

  task automatic test_oor();
    logic       rdy;
    logic       vld;
    logic [7:0] d;
    checks++;
    if (oor_err !== 1'b0) begin errors++; $display("FAIL oor_pre: got %b expected 0", oor_err); end
    p1_access(16'd16, 1'b1, 8'h07, rdy, vld, d);
    checks++;
    if (vld !== 1'b1 || d !== 8'h00 || oor_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_resp: got vld=%b prio=%h err=%b expected vld=1 prio=00 err=1", vld, d, oor_err);
    end
    tick();
    tick();
    checks++;
    if (oor_err !== 1'b1) begin errors++; $display("FAIL oor_sticky: got %b expected 1", oor_err); end
    p1_access(16'd0, 1'b0, 8'h00, rdy, vld, d);
    checks++;
    if (vld !== 1'b1 || d !== 8'hFF) begin
      errors++;
      $display("FAIL oor_entry0: got vld=%b prio=%h expected vld=1 prio=ff", vld, d);
    end
    p1_access(16'h8003, 1'b0, 8'h00, rdy, vld, d);
    checks++;
    if (vld !== 1'b1 || d !== 8'h00) begin
      errors++;
      $display("FAIL oor_upper_bits: got vld=%b prio=%h expected vld=1 prio=00", vld, d);
    end
  endtask

  task automatic test_p0_during_init();
    logic       rdy;
    logic       vld;
    logic       ok;
    logic [7:0] d;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (oor_err !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL init2_reset_clear: got err=%b done=%b expected 0 0", oor_err, init_done);
    end
    for (int i = 0; i < 5; i++) tick();
    p0_req_valid  = 1'b1;
    p0_req_index  = 16'd2;
    p0_req_update = 1'b1;
    p0_req_prio   = 8'h09;
    tick();
    idle_inputs();
    checks++;
    if (p0_resp_valid !== 1'b1 || p0_resp_prio !== 8'hFF || init_done !== 1'b0) begin
      errors++;
      $display("FAIL init_p0_resp: got vld=%b prio=%h done=%b expected 1 ff 0", p0_resp_valid, p0_resp_prio, init_done);
    end
    wait_init(ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL init2_timeout: got done=%b expected 1", init_done); end
    p1_access(16'd2, 1'b0, 8'h00, rdy, vld, d);
    checks++;
    if (vld !== 1'b1 || d !== 8'hFF) begin
      errors++;
      $display("FAIL init_write_dropped: got vld=%b prio=%h expected vld=1 prio=ff", vld, d);
    end
  endtask

  task automatic test_reset_midop();
    logic       rdy;
    logic       vld;
    logic [7:0] d;
    p0_req_valid  = 1'b1;
    p0_req_index  = 16'd5;
    p0_req_update = 1'b1;
    p0_req_prio   = 8'h11;
    tick();
    p0_req_update = 1'b0;
    #1;
    reset_n = 1'b0;
    tick();
    idle_inputs();
    checks++;
    if (p0_resp_valid !== 1'b0 || init_done !== 1'b0 || p0_resp_prio !== 8'h00) begin
      errors++;
      $display("FAIL midop_reset: got vld=%b done=%b prio=%h expected 0 0 00", p0_resp_valid, init_done, p0_resp_prio);
    end
`ifdef TX_PRIO_REG_STATS_EN
    checks++;
    if (p0_ops_cnt !== 32'd0 || p1_stall_cnt !== 32'd0 || upd_cnt !== 32'd0) begin
      errors++;
      $display("FAIL midop_stats: got %0d %0d %0d expected 0 0 0", p0_ops_cnt, p1_stall_cnt, upd_cnt);
    end
`endif
    reset_n = 1'b1;
    for (int i = 1; i <= NE; i++) begin
      tick();
      if (i >= NE - 1) begin
        checks++;
        if (init_done !== (i == NE)) begin
          errors++;
          $display("FAIL midop_sweep_edge%0d: got %b expected %b", i, init_done, (i == NE));
        end
      end
    end
    p1_access(16'd5, 1'b0, 8'h00, rdy, vld, d);
    checks++;
    if (vld !== 1'b1 || d !== 8'hFF) begin
      errors++;
      $display("FAIL midop_entry5: got vld=%b prio=%h expected vld=1 prio=ff", vld, d);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_init_sweep();
    test_raw_p0();
    test_priority();
    test_oor();
    test_p0_during_init();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
